// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data) arbiter onto a single
// memory port. Three-state FSM (IDLE -> BUSY -> RESP) with a registered owner
// and a "last completed grant" bit giving alternating priority on contention.
// Optional feature macro: ARB_TIMEOUT_EN adds a BUSY watchdog that forces a
// zero-data response after TIMEOUT cycles and raises the sticky err_o flag.
module mem_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          if_req_i,
  input  logic [DW-1:0] if_addr_i,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  // data port
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  // memory port
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i,
  // status
  output logic          stall_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          grant_data;
  logic          tmo;
  logic [DW-1:0] rdata_cap;

  // DATA wins unless FETCH is also waiting and DATA had the last completed grant.
  assign grant_data = d_req_i && (!if_req_i || (last_q == OWN_FETCH));

  // Stores and watchdog-forced completions return zero data.
  assign rdata_cap = (mem_ready_i && !mem_we_q) ? mem_rdata_i : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Watchdog fires on the TIMEOUT-th BUSY cycle that sees no ready.
  assign tmo = (state_q == ST_BUSY) && !mem_ready_i && (cnt_q == CW'(TIMEOUT - 1));

  // Count BUSY cycles; held at zero outside BUSY so each access starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    if (tmo) begin
      err_d = 1'b1;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Without the watchdog BUSY waits indefinitely and no error is possible.
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  // Next-state logic: grant in IDLE, wait for completion in BUSY, respond in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_req_i || d_req_i) begin
          state_d = ST_BUSY;
          owner_d = grant_data ? OWN_DATA : OWN_FETCH;
          if (grant_data) begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready_i || tmo) begin
          state_d = ST_RESP;
          last_d  = owner_q;
          if (owner_q == OWN_DATA) begin
            d_rdata_d = rdata_cap;
          end else begin
            if_rdata_d = rdata_cap;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner, latched memory command and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      last_q      <= OWN_FETCH;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == ST_BUSY);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign if_valid_o  = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
  assign d_valid_o   = (state_q == ST_RESP) && (owner_q == OWN_DATA);
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  // Datapath hold while either requester is still waiting for its response.
  assign stall_o = (if_req_i && !if_valid_o) || (d_req_i && !d_valid_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected responses
// (owner + read data) pushed at stimulus time, popped on each valid pulse.
module tb_mem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, mem_ready;
  logic [DW-1:0] if_addr, d_addr, d_wdata, rdata_drv;
  logic          if_valid, d_valid, mem_req, mem_we, stall, err;
  logic [DW-1:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic          model_en;

  typedef struct {
    bit            is_data;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter #(.DW(DW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_valid_o  (if_valid),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_valid_o   (d_valid),
    .d_rdata_o   (d_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata),
    .stall_o     (stall),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [DW-1:0] a);
    return (a * 3) + 32'h1000_0000;
  endfunction

  assign mem_rdata = model_en ? rd_fn(mem_addr) : rdata_drv;

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; rdata_drv = '0; model_en = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      failures++; $display("FAIL reset_mem_cmd got we=%b addr=%h wdata=%h exp=0", mem_we, mem_addr, mem_wdata); end
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got if=%b d=%b exp=0", if_valid, d_valid); end
    checks++; if (if_rdata !== '0 || d_rdata !== '0) begin
      failures++; $display("FAIL reset_rdata got if=%h d=%h exp=0", if_rdata, d_rdata); end
    checks++; if (err !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL reset_err_stall got err=%b stall=%b exp=0", err, stall); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    exp_t e;
    // cycle 0: request sampled in IDLE
    if_req = 1; if_addr = 32'h4; mem_ready = 1; rdata_drv = 32'h0050_0093;
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h0050_0093});
    @(negedge clk); // cycle 1: BUSY
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin
      failures++; $display("FAIL fetch_cycle1 got req=%b addr=%h we=%b exp req=1 addr=4 we=0", mem_req, mem_addr, mem_we); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c1 got=%b exp=1", stall); end
    @(negedge clk); // cycle 2: RESP
    checks++; if (if_valid !== 1'b1 || d_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL fetch_cycle2 got ifv=%b dv=%b req=%b exp 1 0 0", if_valid, d_valid, mem_req); end
    else begin
      e = exp_q.pop_front();
      checks++; if (if_rdata !== e.rdata) begin
        failures++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, e.rdata); end
    end
    if_req = 0; mem_ready = 0;
    @(negedge clk); // cycle 3
    checks++; if (stall !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
      failures++; $display("FAIL fetch_cycle3 got stall=%b ifv=%b rdata=%h exp 0 0 00500093", stall, if_valid, if_rdata); end
    exp_q.delete();
  endtask

  // Both requesters issue together; the scoreboard holds the required order.
  task automatic test_contention(input bit data_first);
    exp_t e;
    int   cyc = 0;
    model_en = 1; mem_ready = 1;
    if_req = 1; if_addr = 32'h8;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    if (data_first) begin
      exp_q.push_back('{is_data: 1'b1, rdata: rd_fn(32'h100)});
      exp_q.push_back('{is_data: 1'b0, rdata: rd_fn(32'h8)});
    end else begin
      exp_q.push_back('{is_data: 1'b0, rdata: rd_fn(32'h8)});
      exp_q.push_back('{is_data: 1'b1, rdata: rd_fn(32'h100)});
    end
    while (exp_q.size() > 0 && cyc < 20) begin
      @(negedge clk); cyc++;
      if (if_valid || d_valid) begin
        e = exp_q.pop_front();
        checks++; if (d_valid !== e.is_data || if_valid !== !e.is_data) begin
          failures++; $display("FAIL contention_order got ifv=%b dv=%b exp data=%b", if_valid, d_valid, e.is_data); end
        checks++; if ((e.is_data ? d_rdata : if_rdata) !== e.rdata) begin
          failures++; $display("FAIL contention_rdata got if=%h d=%h exp=%h", if_rdata, d_rdata, e.rdata); end
        if (if_valid) if_req = 0;
        if (d_valid)  d_req = 0;
      end
    end
    checks++; if (exp_q.size() != 0) begin
      failures++; $display("FAIL contention_timeout got pending=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    if_req = 0; d_req = 0; mem_ready = 0; model_en = 0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin
      failures++; $display("FAIL contention_extra_valid got ifv=%b dv=%b exp 0 0", if_valid, d_valid); end
  endtask

  task automatic test_store();
    exp_t e;
    int   bad = 0;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    mem_ready = 0; rdata_drv = 32'hFFFF_FFFF;
    exp_q.push_back('{is_data: 1'b1, rdata: '0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) bad++;
      if (d_valid !== 1'b0) bad++;
      if (i == 3) mem_ready = 1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL store_busy_hold got bad_cycles=%0d exp=0", bad); end
    @(negedge clk);
    mem_ready = 0;
    checks++; if (d_valid !== 1'b1 || if_valid !== 1'b0) begin
      failures++; $display("FAIL store_valid got dv=%b ifv=%b exp 1 0", d_valid, if_valid); end
    else begin
      e = exp_q.pop_front();
      checks++; if (d_rdata !== e.rdata) begin failures++; $display("FAIL store_rdata got=%h exp=%h", d_rdata, e.rdata); end
    end
    d_req = 0; d_we = 0;
    @(negedge clk);
    checks++; if (d_rdata !== 32'h0 || if_rdata !== rd_fn(32'h8)) begin
      failures++; $display("FAIL rdata_hold got d=%h if=%h exp d=0 if=%h", d_rdata, if_rdata, rd_fn(32'h8)); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int vcnt = 0;
    if_req = 1; if_addr = 32'h40; mem_ready = 0;
    @(negedge clk); // BUSY cycle 1
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", mem_req); end
    @(negedge clk); // BUSY cycle 2
    rst = 1; if_req = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0) begin
      failures++; $display("FAIL rstmid_mem got req=%b addr=%h we=%b wdata=%h exp 0", mem_req, mem_addr, mem_we, mem_wdata); end
    checks++; if (if_rdata !== '0 || d_rdata !== '0 || err !== 1'b0) begin
      failures++; $display("FAIL rstmid_rdata got if=%h d=%h err=%b exp 0", if_rdata, d_rdata, err); end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      if (if_valid || d_valid || mem_req) vcnt++;
      @(negedge clk);
    end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", vcnt); end
  endtask

  task automatic test_req_drop();
    exp_t e;
    int   cyc = 0;
    if_req = 1; if_addr = 32'hC0; mem_ready = 0; model_en = 1;
    exp_q.push_back('{is_data: 1'b0, rdata: rd_fn(32'hC0)});
    @(negedge clk);
    if_req = 0;
    @(negedge clk);
    mem_ready = 1;
    while (exp_q.size() > 0 && cyc < 10) begin
      @(negedge clk); cyc++;
      if (if_valid || d_valid) begin
        e = exp_q.pop_front();
        checks++; if (if_valid !== 1'b1 || if_rdata !== e.rdata) begin
          failures++; $display("FAIL reqdrop_resp got ifv=%b rdata=%h exp 1 %h", if_valid, if_rdata, e.rdata); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL reqdrop_timeout got pending=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    mem_ready = 0; model_en = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    exp_t e;
    int   busy = 0;
    int   cyc = 0;
    bit   seen = 0;
    if_req = 1; if_addr = 32'h80; mem_ready = 0; rdata_drv = 32'h1234_5678;
    exp_q.push_back('{is_data: 1'b0, rdata: '0});
    while (!seen && cyc < 40) begin
      @(negedge clk); cyc++;
      if (mem_req) busy++;
      if (if_valid) begin
        seen = 1;
        e = exp_q.pop_front();
        checks++; if (if_rdata !== e.rdata || err !== 1'b1) begin
          failures++; $display("FAIL timeout_resp got rdata=%h err=%b exp %h 1", if_rdata, err, e.rdata); end
        if_req = 0;
      end
    end
    checks++; if (busy != 16) begin failures++; $display("FAIL timeout_busy_cycles got=%0d exp=16", busy); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err); end
    exp_q.delete();
`else
    int bad_req = 0;
    int vcnt = 0;
    int ecnt = 0;
    if_req = 1; if_addr = 32'h80; mem_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (mem_req !== 1'b1) bad_req++;
      if (if_valid || d_valid) vcnt++;
      if (err !== 1'b0) ecnt++;
      @(negedge clk);
    end
    checks++; if (bad_req != 0) begin failures++; $display("FAIL notmo_req got drops=%0d exp=0", bad_req); end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL notmo_valid got=%0d exp=0", vcnt); end
    checks++; if (ecnt != 0) begin failures++; $display("FAIL notmo_err got=%0d exp=0", ecnt); end
    if_req = 0;
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if (err !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL timeout_reset got err=%b req=%b exp 0 0", err, mem_req); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_reset();
    test_contention(1'b1);   // last grant FETCH -> DATA first
    test_store();            // last grant now DATA
    test_contention(1'b0);   // last grant DATA -> FETCH first
    test_reset_mid();
    test_req_drop();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 16, maximum memory wait in cycles (used only when ARB_TIMEOUT_EN is defined).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch request, held high until if_valid_o.
REQ-006 if_addr_i  in  DW  fetch byte address, stable while if_req_i is high.
REQ-007 d_req_i  in  1  data request, held high until d_valid_o.
REQ-008 d_we_i  in  1  data write enable (1 = store, 0 = load).
REQ-009 d_addr_i  in  DW  data byte address, stable while d_req_i is high.
REQ-010 d_wdata_i  in  DW  store data.
REQ-011 mem_req_o  out  1  memory access strobe.
REQ-012 mem_we_o  out  1  memory write enable.
REQ-013 mem_addr_o  out  DW  memory address.
REQ-014 mem_wdata_o  out  DW  memory write data.
REQ-015 mem_ready_i  in  1  memory completes the current access this cycle.
REQ-016 mem_rdata_i  in  DW  read data, valid when mem_ready_i is high.
REQ-017 if_valid_o / if_rdata_o  out  1 / DW  fetch complete pulse and instruction word.
REQ-018 d_valid_o / d_rdata_o  out  1 / DW  data complete pulse and load data (0 for stores).
REQ-019 stall_o  out  1  datapath hold; PC and register-file writes are frozen while it is high.
REQ-020 err_o  out  1  sticky timeout flag.

Function
REQ-021 The arbiter SHALL implement states IDLE, BUSY and RESP, with a registered owner bit (FETCH or DATA).
REQ-022 IDLE: with no request pending, the arbiter SHALL stay in IDLE.
REQ-023 IDLE: with any request pending, the arbiter SHALL go to BUSY, latch the owner and latch addr, we and wdata onto the mem_* outputs.
REQ-024 Grant: with only one request pending, that requester SHALL win.
REQ-025 Grant: with both pending, DATA SHALL win unless the last completed grant was DATA, in which case FETCH SHALL win.
REQ-026 A fetch grant SHALL drive mem_we_o=0.
REQ-027 BUSY: mem_req_o SHALL be 1 and the mem_* outputs SHALL be held constant.
REQ-028 BUSY: on mem_ready_i=1 the arbiter SHALL capture mem_rdata_i (0 if mem_we_o) and go to RESP.
REQ-029 RESP: the owner's valid output SHALL be 1 for exactly one cycle with the captured rdata; mem_req_o SHALL be 0; next state SHALL be IDLE.
REQ-030 In RESP the arbiter SHALL NOT grant; requesters drop req in the cycle after valid.
REQ-031 Minimum latency SHALL be 2 cycles: req sampled in IDLE at cycle 0, mem_req_o high in cycle 1, ready in cycle 1, valid in cycle 2.
REQ-032 The non-owner's valid output SHALL remain 0 throughout.
REQ-033 rdata outputs SHALL hold their last value outside RESP.
REQ-034 stall_o SHALL equal (if_req_i & ~if_valid_o) | (d_req_i & ~d_valid_o), computed combinationally.
REQ-035 A request deasserted while BUSY is a protocol violation; the access SHALL still complete normally.

Reset
REQ-036 On rst=1 at a clock edge: state=IDLE, last grant=FETCH, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, both valid outputs=0, both rdata outputs=0, err_o=0, timeout counter=0.
REQ-037 Reset during BUSY or RESP SHALL abandon the access with no valid pulse; mem_req_o SHALL be 0 from the next cycle.

Configuration
REQ-038 Macro ARB_TIMEOUT_EN defined: a counter SHALL count BUSY cycles, clearing on entry to BUSY.
REQ-039 ARB_TIMEOUT_EN defined: if TIMEOUT cycles elapse in BUSY without mem_ready_i, the arbiter SHALL go to RESP with rdata=0 and set err_o=1 until reset.
REQ-040 ARB_TIMEOUT_EN undefined: no counter SHALL exist, BUSY SHALL wait indefinitely and err_o SHALL be tied to 0.

Verification
REQ-041 Fetch only: if_req_i=1, if_addr_i=0x4, mem_ready_i=1 immediately, mem_rdata_i=0x00500093 -> mem_addr_o=0x4 in cycle 1, if_valid_o=1 with if_rdata_o=0x00500093 in cycle 2, stall_o low from cycle 3.
REQ-042 Contention: if_req_i=1 and d_req_i=1 (load 0x100) together, last grant FETCH -> DATA is served first, then FETCH; each valid pulses once, in that order.
REQ-043 Store: d_we_i=1, d_addr_i=0x20, d_wdata_i=0xDEADBEEF, ready after 3 wait cycles -> mem_we_o=1 with stable address and data for 4 cycles, d_valid_o=1 with d_rdata_o=0.
REQ-044 Reset mid-access: rst=1 in the second BUSY cycle -> mem_req_o=0 next cycle, no valid pulse, all outputs at reset values.
REQ-045 ARB_TIMEOUT_EN defined, TIMEOUT=16, mem_ready_i held 0 -> owner valid with rdata=0 after 16 BUSY cycles, err_o=1 until rst.
REQ-046 ARB_TIMEOUT_EN undefined, same stimulus for 100 cycles -> mem_req_o stays 1, no valid pulse, err_o=0.
